// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing data-memory port s2 between two Avalon-MM-style requesters.
// Optional burst-lock tie-break priority is built when DMEM_ARB_BURST_LOCK_EN is defined.
module dmem_port_arbiter #(
   parameter int ADDR_W    = 10,
   parameter int DATA_W    = 32,
   parameter int MAX_BURST = 8
) (
   input  logic                clk,
   input  logic                reset_n,

   input  logic                r0_req,
   input  logic                r0_write,
   input  logic [ADDR_W-1:0]   r0_address,
   input  logic [DATA_W/8-1:0] r0_byteenable,
   input  logic [DATA_W-1:0]   r0_writedata,
   output logic                r0_waitrequest,
   output logic [DATA_W-1:0]   r0_readdata,
   output logic                r0_readdatavalid,
   input  logic                r0_lock,

   input  logic                r1_req,
   input  logic                r1_write,
   input  logic [ADDR_W-1:0]   r1_address,
   input  logic [DATA_W/8-1:0] r1_byteenable,
   input  logic [DATA_W-1:0]   r1_writedata,
   output logic                r1_waitrequest,
   output logic [DATA_W-1:0]   r1_readdata,
   output logic                r1_readdatavalid,
   input  logic                r1_lock,

   output logic [ADDR_W-1:0]   mem_address,
   output logic [DATA_W/8-1:0] mem_byteenable,
   output logic                mem_chipselect,
   output logic                mem_write,
   output logic [DATA_W-1:0]   mem_writedata,
   output logic                mem_clken,
   input  logic [DATA_W-1:0]   mem_readdata
);

   localparam int BE_W = DATA_W / 8;

   logic last_grant_q, last_grant_d;
   logic rd_pend_q, rd_pend_d;
   logic rd_owner_q, rd_owner_d;

   logic                grant0, grant1;
   logic                accept;
   logic                gnt_idx;
   logic                tie_pick;
   logic                sel_write;
   logic [ADDR_W-1:0]   sel_address;
   logic [BE_W-1:0]     sel_byteenable;
   logic [DATA_W-1:0]   sel_writedata;

`ifdef DMEM_ARB_BURST_LOCK_EN
   localparam int CNT_W = $clog2(MAX_BURST + 1);

   logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
   logic [CNT_W-1:0] cnt_inc;
   logic             owner_lock;
   logic             owner_req;
   logic             sel_lock;
   logic             keep_prio;

   assign owner_lock = last_grant_q ? r1_lock : r0_lock;
   assign owner_req  = last_grant_q ? r1_req  : r0_req;
   assign sel_lock   = gnt_idx ? r1_lock : r0_lock;
   // A nonzero count means the last grantee is mid-burst and still holds its lock.
   assign keep_prio  = (burst_cnt_q != '0) & owner_lock;
   assign tie_pick   = keep_prio ? last_grant_q : ~last_grant_q;

   always_comb begin
      burst_cnt_d = burst_cnt_q;
      cnt_inc     = CNT_W'(1);
      if (accept) begin
         if (sel_lock) begin
            if ((gnt_idx == last_grant_q) && (burst_cnt_q != '0)) begin
               cnt_inc = burst_cnt_q + CNT_W'(1);
            end
            burst_cnt_d = (cnt_inc == CNT_W'(MAX_BURST)) ? '0 : cnt_inc;
         end else begin
            burst_cnt_d = '0;
         end
      end else if (!owner_req || !owner_lock) begin
         burst_cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         burst_cnt_q <= '0;
      end else begin
         burst_cnt_q <= burst_cnt_d;
      end
   end
`else
   logic unused_lock;

   assign unused_lock = r0_lock ^ r1_lock ^ (MAX_BURST == 0);
   assign tie_pick    = ~last_grant_q;
`endif

   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (reset_n) begin
         if (r0_req && r1_req) begin
            grant0 = ~tie_pick;
            grant1 = tie_pick;
         end else begin
            grant0 = r0_req;
            grant1 = r1_req;
         end
      end
   end

   assign accept  = grant0 | grant1;
   assign gnt_idx = grant1;

   assign r0_waitrequest = ~reset_n | (r0_req & ~grant0);
   assign r1_waitrequest = ~reset_n | (r1_req & ~grant1);

   assign sel_write      = gnt_idx ? r1_write      : r0_write;
   assign sel_address    = gnt_idx ? r1_address    : r0_address;
   assign sel_byteenable = gnt_idx ? r1_byteenable : r0_byteenable;
   assign sel_writedata  = gnt_idx ? r1_writedata  : r0_writedata;

   always_comb begin
      mem_chipselect = 1'b0;
      mem_write      = 1'b0;
      mem_address    = '0;
      mem_byteenable = '0;
      mem_writedata  = '0;
      if (accept) begin
         mem_chipselect = 1'b1;
         mem_write      = sel_write;
         mem_address    = sel_address;
         mem_byteenable = sel_write ? sel_byteenable : '1;
         mem_writedata  = sel_writedata;
      end
   end

   assign mem_clken = 1'b1;

   always_comb begin
      last_grant_d = last_grant_q;
      rd_pend_d    = accept & ~sel_write;
      rd_owner_d   = rd_owner_q;
      if (accept) begin
         last_grant_d = gnt_idx;
         if (!sel_write) begin
            rd_owner_d = gnt_idx;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         last_grant_q <= 1'b1;
         rd_pend_q    <= 1'b0;
         rd_owner_q   <= 1'b0;
      end else begin
         last_grant_q <= last_grant_d;
         rd_pend_q    <= rd_pend_d;
         rd_owner_q   <= rd_owner_d;
      end
   end

   // Gated by reset_n so a read accepted just before reset never returns data.
   assign r0_readdatavalid = reset_n & rd_pend_q & ~rd_owner_q;
   assign r1_readdatavalid = reset_n & rd_pend_q &  rd_owner_q;
   assign r0_readdata      = mem_readdata;
   assign r1_readdata      = mem_readdata;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a behavioural 1024x32 byte-lane memory (1-cycle read).
module tb_dmem_port_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        r0_req, r0_write, r0_lock;
   logic [9:0]  r0_address;
   logic [3:0]  r0_byteenable;
   logic [31:0] r0_writedata;
   logic        r0_waitrequest, r0_readdatavalid;
   logic [31:0] r0_readdata;
   logic        r1_req, r1_write, r1_lock;
   logic [9:0]  r1_address;
   logic [3:0]  r1_byteenable;
   logic [31:0] r1_writedata;
   logic        r1_waitrequest, r1_readdatavalid;
   logic [31:0] r1_readdata;
   logic [9:0]  mem_address;
   logic [3:0]  mem_byteenable;
   logic        mem_chipselect, mem_write, mem_clken;
   logic [31:0] mem_writedata;
   logic [31:0] mem_readdata = '0;

   int n_total = 0;
   int n_pass  = 0;

   always #5 clk = ~clk;

   dmem_port_arbiter #(.ADDR_W(10), .DATA_W(32), .MAX_BURST(4)) dut (
      .clk(clk), .reset_n(reset_n),
      .r0_req(r0_req), .r0_write(r0_write), .r0_address(r0_address),
      .r0_byteenable(r0_byteenable), .r0_writedata(r0_writedata),
      .r0_waitrequest(r0_waitrequest), .r0_readdata(r0_readdata),
      .r0_readdatavalid(r0_readdatavalid), .r0_lock(r0_lock),
      .r1_req(r1_req), .r1_write(r1_write), .r1_address(r1_address),
      .r1_byteenable(r1_byteenable), .r1_writedata(r1_writedata),
      .r1_waitrequest(r1_waitrequest), .r1_readdata(r1_readdata),
      .r1_readdatavalid(r1_readdatavalid), .r1_lock(r1_lock),
      .mem_address(mem_address), .mem_byteenable(mem_byteenable),
      .mem_chipselect(mem_chipselect), .mem_write(mem_write),
      .mem_writedata(mem_writedata), .mem_clken(mem_clken),
      .mem_readdata(mem_readdata)
   );

   function automatic logic [31:0] pat(input logic [9:0] a);
      if (a == 10'h010) return 32'hDEADBEEF;
      if (a == 10'h3FF) return 32'hFFFFFFFF;
      return 32'hC0DE_0000 | {22'd0, a};
   endfunction

   logic [31:0] mem_arr [0:1023];
   logic        mem_ready = 1'b0;

   always @(posedge clk) begin
      if (!mem_ready) begin
         for (int i = 0; i < 1024; i++) mem_arr[i] <= pat(10'(i));
         mem_ready <= 1'b1;
      end else if (mem_chipselect) begin
         if (mem_write) begin
            for (int b = 0; b < 4; b++)
               if (mem_byteenable[b]) mem_arr[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
         end else begin
            mem_readdata <= mem_arr[mem_address];
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      else n_pass++;
   endtask

   typedef struct {
      logic q0, w0; logic [9:0] a0; logic [3:0] be0; logic [31:0] d0;
      logic q1, w1; logic [9:0] a1; logic [3:0] be1; logic [31:0] d1;
      logic e_wt0, e_wt1, e_cs, e_wr; logic [9:0] e_addr; logic [3:0] e_be; logic [31:0] e_wd;
      logic e_v0, e_v1; logic [31:0] e_rd;
   } vec_t;

   vec_t vecs [12];

   task automatic idle_inputs();
      r0_req = 0; r0_write = 0; r0_address = '0; r0_byteenable = '0; r0_writedata = '0; r0_lock = 0;
      r1_req = 0; r1_write = 0; r1_address = '0; r1_byteenable = '0; r1_writedata = '0; r1_lock = 0;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset_n = 0;
      r0_req = 1; r1_req = 1;
      @(negedge clk);
      chk("rst_wait0", 32'(r0_waitrequest), 32'd1);
      chk("rst_wait1", 32'(r1_waitrequest), 32'd1);
      chk("rst_cs",    32'(mem_chipselect), 32'd0);
      chk("rst_wr",    32'(mem_write),      32'd0);
      chk("rst_rdv",   32'({r0_readdatavalid, r1_readdatavalid}), 32'd0);
      @(posedge clk); #1;
      idle_inputs();
      reset_n = 1;
   endtask

   logic [9:0] ca0, ca1, pa;
   logic       pg, eg;

   initial begin
      reset_n = 0;
      idle_inputs();
      vecs[0]  = '{1,0,10'h010,4'h0,32'h0, 0,0,10'h000,4'h0,32'h0, 0,0,1,0,10'h010,4'hF,32'h0, 0,0,32'h0};
      vecs[1]  = '{0,0,10'h000,4'h0,32'h0, 0,0,10'h000,4'h0,32'h0, 0,0,0,0,10'h000,4'h0,32'h0, 1,0,32'hDEADBEEF};
      vecs[2]  = '{1,0,10'h000,4'h0,32'h0, 1,0,10'h100,4'h0,32'h0, 1,0,1,0,10'h100,4'hF,32'h0, 0,0,32'h0};
      vecs[3]  = '{1,0,10'h000,4'h0,32'h0, 1,0,10'h101,4'h0,32'h0, 0,1,1,0,10'h000,4'hF,32'h0, 0,1,32'hC0DE0100};
      vecs[4]  = '{1,0,10'h001,4'h0,32'h0, 1,0,10'h101,4'h0,32'h0, 1,0,1,0,10'h101,4'hF,32'h0, 1,0,32'hC0DE0000};
      vecs[5]  = '{0,0,10'h000,4'h0,32'h0, 1,1,10'h3FF,4'h5,32'h11223344, 0,0,1,1,10'h3FF,4'h5,32'h11223344, 0,1,32'hC0DE0101};
      vecs[6]  = '{1,0,10'h3FF,4'h0,32'h0, 0,0,10'h000,4'h0,32'h0, 0,0,1,0,10'h3FF,4'hF,32'h0, 0,0,32'h0};
      vecs[7]  = '{0,0,10'h000,4'h0,32'h0, 0,0,10'h000,4'h0,32'h0, 0,0,0,0,10'h000,4'h0,32'h0, 1,0,32'hFF22FF44};
      vecs[8]  = '{1,1,10'h005,4'hF,32'hAABBCCDD, 1,0,10'h3FF,4'h0,32'h0, 1,0,1,0,10'h3FF,4'hF,32'h0, 0,0,32'h0};
      vecs[9]  = '{1,1,10'h005,4'hF,32'hAABBCCDD, 0,0,10'h000,4'h0,32'h0, 0,0,1,1,10'h005,4'hF,32'hAABBCCDD, 0,1,32'hFF22FF44};
      vecs[10] = '{0,0,10'h000,4'h0,32'h0, 1,0,10'h005,4'h0,32'h0, 0,0,1,0,10'h005,4'hF,32'h0, 0,0,32'h0};
      vecs[11] = '{0,0,10'h000,4'h0,32'h0, 0,0,10'h000,4'h0,32'h0, 0,0,0,0,10'h000,4'h0,32'h0, 0,1,32'hAABBCCDD};

      do_reset();
      chk("clken", 32'(mem_clken), 32'd1);

      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         r0_req = vecs[i].q0; r0_write = vecs[i].w0; r0_address = vecs[i].a0;
         r0_byteenable = vecs[i].be0; r0_writedata = vecs[i].d0;
         r1_req = vecs[i].q1; r1_write = vecs[i].w1; r1_address = vecs[i].a1;
         r1_byteenable = vecs[i].be1; r1_writedata = vecs[i].d1;
         @(negedge clk);
         chk($sformatf("v%0d_wait0", i), 32'(r0_waitrequest),   32'(vecs[i].e_wt0));
         chk($sformatf("v%0d_wait1", i), 32'(r1_waitrequest),   32'(vecs[i].e_wt1));
         chk($sformatf("v%0d_cs", i),    32'(mem_chipselect),   32'(vecs[i].e_cs));
         chk($sformatf("v%0d_wr", i),    32'(mem_write),        32'(vecs[i].e_wr));
         chk($sformatf("v%0d_addr", i),  32'(mem_address),      32'(vecs[i].e_addr));
         chk($sformatf("v%0d_be", i),    32'(mem_byteenable),   32'(vecs[i].e_be));
         chk($sformatf("v%0d_wd", i),    mem_writedata,         vecs[i].e_wd);
         chk($sformatf("v%0d_rdv0", i),  32'(r0_readdatavalid), 32'(vecs[i].e_v0));
         chk($sformatf("v%0d_rdv1", i),  32'(r1_readdatavalid), 32'(vecs[i].e_v1));
         if (vecs[i].e_v0) chk($sformatf("v%0d_rd0", i), r0_readdata, vecs[i].e_rd);
         if (vecs[i].e_v1) chk($sformatf("v%0d_rd1", i), r1_readdata, vecs[i].e_rd);
      end

      // Continuous contention from reset: strict alternation starting with r0.
      do_reset();
      ca0 = 10'h000; ca1 = 10'h100; pg = 0; pa = '0;
      r0_req = 1; r0_address = ca0; r1_req = 1; r1_address = ca1;
      for (int k = 0; k < 8; k++) begin
         eg = k[0];
         @(negedge clk);
         chk($sformatf("cont%0d_wait0", k), 32'(r0_waitrequest), 32'(eg));
         chk($sformatf("cont%0d_wait1", k), 32'(r1_waitrequest), 32'(!eg));
         chk($sformatf("cont%0d_addr", k),  32'(mem_address), 32'(eg ? ca1 : ca0));
         if (k > 0) begin
            chk($sformatf("cont%0d_rdv0", k), 32'(r0_readdatavalid), 32'(!pg));
            chk($sformatf("cont%0d_rdv1", k), 32'(r1_readdatavalid), 32'(pg));
            chk($sformatf("cont%0d_rdata", k), mem_readdata, pat(pa));
         end
         pg = eg; pa = eg ? ca1 : ca0;
         @(posedge clk); #1;
         if (eg) ca1 = ca1 + 10'd1; else ca0 = ca0 + 10'd1;
         r0_address = ca0; r1_address = ca1;
      end
      @(negedge clk);
      chk("cont_last_rdv1", 32'(r1_readdatavalid), 32'(pg));
      idle_inputs();

      // Reset arriving the cycle after an accepted read suppresses the return.
      do_reset();
      r0_req = 1; r0_address = 10'h020;
      @(negedge clk);
      chk("rmid_accept", 32'(r0_waitrequest), 32'd0);
      @(posedge clk); #1;
      r0_req = 0; reset_n = 0;
      @(negedge clk);
      chk("rmid_rdv0_a", 32'(r0_readdatavalid | r1_readdatavalid), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("rmid_rdv0_b", 32'(r0_readdatavalid | r1_readdatavalid), 32'd0);
      @(posedge clk); #1;
      reset_n = 1;
      r0_req = 1; r0_address = 10'h030; r1_req = 1; r1_address = 10'h130;
      @(negedge clk);
      chk("rmid_first_wait0", 32'(r0_waitrequest), 32'd0);
      chk("rmid_first_wait1", 32'(r1_waitrequest), 32'd1);
      @(posedge clk); #1;
      idle_inputs();
      @(posedge clk); #1;

      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         chk($sformatf("idle%0d_cs", k),   32'(mem_chipselect), 32'd0);
         chk($sformatf("idle%0d_wait", k), 32'({r0_waitrequest, r1_waitrequest}), 32'd0);
         chk($sformatf("idle%0d_rdv", k),  32'({r0_readdatavalid, r1_readdatavalid}), 32'd0);
      end

      // Lock behaviour: burst of MAX_BURST=4 for r0 when built, otherwise ignored.
      do_reset();
      r0_req = 1; r0_lock = 1; r0_address = 10'h040; r1_req = 1; r1_address = 10'h140;
      for (int k = 0; k < 10; k++) begin
`ifdef DMEM_ARB_BURST_LOCK_EN
         eg = ((k % 5) == 4);
`else
         eg = k[0];
`endif
         @(negedge clk);
         chk($sformatf("lock%0d_wait0", k), 32'(r0_waitrequest), 32'(eg));
         chk($sformatf("lock%0d_wait1", k), 32'(r1_waitrequest), 32'(!eg));
         @(posedge clk); #1;
      end
      idle_inputs();
      @(posedge clk); #1;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Round-robin arbiter that shares the second port (s2) of the 1024x32 on-chip data memory between two accelerator requesters, e.g. the CNN feature-map reader and the result write-back engine.
- Each requester gets an Avalon-MM-style handshake with waitrequest and readdatavalid.
- The arbiter drives a single memory port: 10-bit word address, 4-bit byteenable, 1-cycle read latency.

Parameters:
- ADDR_W, 10, word address width (1024 words).
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- MAX_BURST, 8, maximum consecutive grants while a lock is held. Used only with the optional feature; must be >= 1.

Ports:
- clk  in  1  system clock; memory port is clocked by the same clk.
- reset_n  in  1  synchronous, active-low reset.
- r0_req  in  1  requester 0 transaction request.
- r0_write  in  1  1=write, 0=read.
- r0_address  in  ADDR_W  word address.
- r0_byteenable  in  DATA_W/8  byte lanes for writes.
- r0_writedata  in  DATA_W  write data.
- r0_waitrequest  out  1  high = request not accepted this cycle.
- r0_readdata  out  DATA_W  read data.
- r0_readdatavalid  out  1  read data valid.
- r0_lock  in  1  burst lock hold (optional feature only; ignored otherwise).
- r1_*  same set as r0_*, for requester 1.
- mem_address  out  ADDR_W  to memory address2.
- mem_byteenable  out  DATA_W/8  to memory byteenable2.
- mem_chipselect  out  1  to memory chipselect2.
- mem_write  out  1  to memory write2.
- mem_writedata  out  DATA_W  to memory writedata2.
- mem_clken  out  1  to memory clken2; constant 1.
- mem_readdata  in  DATA_W  from memory readdata2.

Behaviour:
- Clock and reset: all state uses clk; reset_n is synchronous and active-low.
- Registered state:
  - last_grant (1 bit, reset 1, so r0 wins the first contention).
  - rd_pend (1 bit, reset 0).
  - rd_owner (1 bit, reset 0).
  - burst_cnt (reset 0, optional feature).
- Grant decision (combinational, same cycle):
  - Only one requester asserts req: it is granted.
  - Both assert req: the requester != last_grant is granted.
  - Neither asserts req: no grant.
  - During reset (reset_n=0): no grant; both waitrequests high.
- Waitrequest: rX_waitrequest = rX_req & ~grantX. When rX_req=0, waitrequest=0.
- Acceptance: a transaction is accepted when req=1 and waitrequest=0. The requester must hold all its inputs stable until accepted.
- Memory drive on an accepted cycle:
  - mem_chipselect=1.
  - mem_address, mem_byteenable, mem_write, mem_writedata are muxed from the granted requester.
  - For reads, mem_byteenable is forced to all-ones.
- Memory drive otherwise: mem_chipselect=0, mem_write=0, mem_address/byteenable/writedata = 0.
- last_grant update: on acceptance, last_grant <= granted index.
- Read return:
  - On an accepted read, rd_pend<=1 and rd_owner<=index at the next edge.
  - rX_readdatavalid = rd_pend & (rd_owner==X), asserted exactly 1 cycle after acceptance.
  - r0_readdata and r1_readdata are both wired to mem_readdata and are meaningful only while the matching readdatavalid is high.
  - rd_pend clears the cycle after, unless another read is accepted. Back-to-back reads give one readdatavalid per cycle.
- Writes: complete at the acceptance edge; no response. A read of the same address in the next cycle returns the new data.
- Throughput: one transaction per cycle, no idle cycles between grants.
- Reset output values: waitrequest = req-independent high; readdatavalid=0; mem_chipselect=0; mem_write=0.
- Reset mid-operation: asserting reset_n=0 with a read accepted in the previous cycle clears rd_pend, so no readdatavalid is issued.
- Fairness: with both requesters continuously requesting, the grant sequence alternates 0,1,0,1...

Optional Feature:
- Macro: DMEM_ARB_BURST_LOCK_EN.
- Defined:
  - A granted requester holding rX_lock=1 keeps priority on ties for up to MAX_BURST consecutive accepted transactions.
  - burst_cnt increments per accepted transaction of the lock owner.
  - On reaching MAX_BURST, or when lock drops, or when the owner's req drops, priority reverts to round-robin and burst_cnt resets to 0.
  - The lock only overrides the tie-break; an idle owner never blocks the other requester.
- Undefined: lock inputs are ignored, burst_cnt is not built, and behaviour is pure round-robin.

Test Plan:
- Single read: mem[0x010]=0xDEADBEEF; r0 read 0x010 -> r0_waitrequest=0 same cycle; r0_readdatavalid=1 with 0xDEADBEEF next cycle; r1_readdatavalid stays 0.
- Contention: both requesters assert continuous reads (r0 at 0x000.., r1 at 0x100..) from reset -> grants r0,r1,r0,r1; each readdatavalid lands on its owner one cycle after its grant.
- Byte-lane write: r1 writes 0x11223344 with be=4'b0101 to 0x3FF (old 0xFFFFFFFF) -> r0 reading 0x3FF the next cycle gets 0xFF22FF44.
- Reset mid-read: r0 read accepted, reset_n=0 on the following cycle -> no readdatavalid; after release, the first contention grants r0.
- Burst lock (macro defined, MAX_BURST=4): both requesters request continuously, r0_lock=1 -> r0 is granted 4 times, then r1 once, then r0 regains priority.
- Idle: no requests -> mem_chipselect=0, both waitrequests 0, no readdatavalid for 20 cycles.
